tx_queue: RTL

TX_QUEUE -- requirements
Module: tx_queue

---
 rtl/uart_pkg.sv | 21 ++
 rtl/byte_fifo.sv | 73 +++++++
 rtl/tx_queue.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state constants and the tx_queue drain FSM encodings.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    UTX_IDLE  = 2'd0,
    UTX_START = 2'd1,
    UTX_DATA  = 2'd2,
    UTX_STOP  = 2'd3
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    DRAIN_IDLE      = 3'd0,
    DRAIN_ISSUE     = 3'd1,
    DRAIN_WAIT_BUSY = 3'd2,
    DRAIN_WAIT_DONE = 3'd3,
    DRAIN_RELEASE   = 3'd4
  } drain_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered count/empty/full flags; a push while full is dropped even if a pop occurs.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              not_full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_s;
  logic              empty_r;
  logic              full_r;
  logic              not_full_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Acceptance is judged against the registered flags, so a full queue drops a push even on a pop cycle.
  always_comb begin
    push_ok_s = push && !full_r;
    pop_ok_s  = pop && !empty_r;
    count_s   = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + (AW+1)'(1);
      2'b01:   count_s = count_r - (AW+1)'(1);
      default: count_s = count_r;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      not_full_r <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r    <= count_s;
      empty_r    <= (count_s == '0);
      full_r     <= (count_s == DEPTH_C);
      not_full_r <= (count_s != DEPTH_C);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign not_full = not_full_r;

endmodule

// File: rtl/tx_queue.sv
// Transmit byte queue feeding a UART transmitter; a drain FSM launches one byte per full busy/done handshake.
module tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  input  logic [BYTE_W-1:0] wr_byte,
  output logic              wr_ready,
  output logic              overflow,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_busy,
  input  logic              tx_done
);

  drain_state_t      state_r;
  drain_state_t      state_s;
  logic              tx_valid_r;
  logic [BYTE_W-1:0] tx_byte_r;
  logic              overflow_r;
  logic [BYTE_W-1:0] head_s;
  logic              empty_s;
  logic              full_s;
  logic              not_full_s;

  // The head is popped in the same cycle the registered launch strobe is high.
  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (wr_valid),
    .din      (wr_byte),
    .pop      (tx_valid_r),
    .head     (head_s),
    .count    (count),
    .empty    (empty_s),
    .full     (full_s),
    .not_full (not_full_s)
  );

  always_comb begin
    state_s = state_r;
    case (state_r)
      DRAIN_IDLE:      if (!empty_s && !tx_busy && !tx_done) state_s = DRAIN_ISSUE;
                       else state_s = DRAIN_IDLE;
      DRAIN_ISSUE:     state_s = DRAIN_WAIT_BUSY;
      DRAIN_WAIT_BUSY: if (tx_busy) state_s = DRAIN_WAIT_DONE;
                       else state_s = DRAIN_WAIT_BUSY;
      DRAIN_WAIT_DONE: if (tx_done) state_s = DRAIN_RELEASE;
                       else state_s = DRAIN_WAIT_DONE;
      DRAIN_RELEASE:   if (!tx_done) state_s = DRAIN_IDLE;
                       else state_s = DRAIN_RELEASE;
      default:         state_s = DRAIN_IDLE;
    endcase
  end

  // tx_byte is only loaded on ISSUE, so it holds steady across the launch strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= DRAIN_IDLE;
      tx_valid_r <= 1'b0;
      tx_byte_r  <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      tx_valid_r <= (state_r == DRAIN_ISSUE);
      if (state_r == DRAIN_ISSUE) tx_byte_r <= head_s;
      overflow_r <= wr_valid && full_s;
    end
  end

  assign wr_ready = not_full_s;
  assign overflow = overflow_r;
  assign empty    = empty_s;
  assign full     = full_s;
  assign tx_valid = tx_valid_r;
  assign tx_byte  = tx_byte_r;

endmodule
